// File: rtl/fft_out_reorder.sv
// fft_out_reorder: ping-pong bank buffer turning bit-reversed MDC FFT pairs into a natural-order bin stream
module fft_out_reorder #(
  parameter int DW = 9,
  parameter int N = 32,
  parameter int LOG2N = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_up_re,
  input  logic [DW-1:0]    in_up_im,
  input  logic [DW-1:0]    in_dn_re,
  input  logic [DW-1:0]    in_dn_im,
  output logic             out_valid,
  output logic [DW-1:0]    out_re,
  output logic [DW-1:0]    out_im,
  output logic [LOG2N-1:0] out_idx,
  output logic             out_sof,
  output logic             ovf
);
  typedef enum logic [1:0] {EMPTY, FULL, READING} bank_t;
  typedef enum logic {IDLE, READ} rd_t;
  bank_t st [2];
  rd_t state;
  logic wr_bank, rd_bank, rd_last, wr_ok;
  logic [LOG2N-2:0] k;
  logic [LOG2N-2:0] kr;
  logic [LOG2N-1:0] raddr;
  logic [2*DW-1:0] mem [2*N];
  assign rd_last = state == READ && raddr == LOG2N'(N - 1);
  // a bank finishing its last read this cycle already counts as free for the writer
  assign wr_ok = in_valid && (st[wr_bank] == EMPTY || (rd_last && rd_bank == wr_bank));
  assign kr = {k[0], k[1], k[2], k[3]};
  // pair k lands at bitrev5(2k) (Up) and bitrev5(2k)+16 (Down)
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[{wr_bank, 1'b0, kr}] <= {in_up_re, in_up_im};
      mem[{wr_bank, 1'b1, kr}] <= {in_dn_re, in_dn_im};
    end
  end
  // bank bookkeeping, read sequencing and registered output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st[0] <= EMPTY;
      st[1] <= EMPTY;
      state <= IDLE;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      k <= '0;
      raddr <= '0;
      out_valid <= 1'b0;
      out_re <= '0;
      out_im <= '0;
      out_idx <= '0;
      out_sof <= 1'b0;
      ovf <= 1'b0;
    end else begin
      out_valid <= state == READ;
      out_sof <= state == READ && raddr == '0;
      if (state == READ) begin
        {out_re, out_im} <= mem[{rd_bank, raddr}];
        out_idx <= raddr;
      end
      if (in_valid && !wr_ok) ovf <= 1'b1;
      if (state == IDLE) begin
        if (st[rd_bank] == FULL) begin
          state <= READ;
          st[rd_bank] <= READING;
          raddr <= '0;
        end
      end else begin
        raddr <= raddr + 1'b1;
        if (rd_last) begin
          st[rd_bank] <= EMPTY;
          rd_bank <= !rd_bank;
          if (st[!rd_bank] == FULL) st[!rd_bank] <= READING;
          else state <= IDLE;
        end
      end
      // writer updates come last so a write into a just-freed bank wins
      if (wr_ok) begin
        k <= k + 1'b1;
        if (k == '1) begin
          st[wr_bank] <= FULL;
          wr_bank <= !wr_bank;
        end
      end
    end
  end
endmodule

// File: tb/tb_fft_out_reorder.sv
// tb_fft_out_reorder: directed scenario checks of the FFT output reorder buffer
module tb_fft_out_reorder;
  localparam int DW = 9;
  logic clk = 0, rst = 1, in_valid = 0;
  logic [DW-1:0] in_up_re = 0, in_up_im = 0, in_dn_re = 0, in_dn_im = 0;
  logic out_valid, out_sof, ovf;
  logic [DW-1:0] out_re, out_im;
  logic [4:0] out_idx;
  int total = 0, bad = 0, cyc = 0, t_last = 0;

  fft_out_reorder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_up_re(in_up_re), .in_up_im(in_up_im), .in_dn_re(in_dn_re), .in_dn_im(in_dn_im),
    .out_valid(out_valid), .out_re(out_re), .out_im(out_im), .out_idx(out_idx),
    .out_sof(out_sof), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int br5(input int x);
    logic [4:0] v;
    v = 5'(x);
    return int'({v[0], v[1], v[2], v[3], v[4]});
  endfunction

  task automatic set_pair(input int p, input int off);
    int b;
    b = br5(2 * p);
    in_valid = 1;
    in_up_re = DW'(b + off);
    in_up_im = DW'(-(b + off));
    in_dn_re = DW'(b + 16 + off);
    in_dn_im = DW'(-(b + 16 + off));
  endtask

  task automatic drive_frame(input int off, input bit gaps);
    for (int p = 0; p < 16; p++) begin
      if (gaps) begin
        @(negedge clk);
        in_valid = 0;
      end
      @(negedge clk);
      set_pair(p, off);
      if (p == 15) t_last = cyc + 1;
    end
  endtask

  task automatic collect(input int n, input int off0, input int off1, output int first);
    int w, b, off;
    w = 0;
    first = -1;
    @(negedge clk);
    while (!out_valid && w < 300) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL wait_valid: out_valid=%b required 1 within 300 cycles", out_valid);
      return;
    end
    first = cyc;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      b = i % 32;
      off = i < 32 ? off0 : off1;
      total++;
      if (out_valid !== 1'b1 || out_idx !== 5'(b) || $signed(out_re) !== b + off ||
          $signed(out_im) !== -(b + off) || out_sof !== (b == 0)) begin
        bad++;
        $display("FAIL bin%0d: valid=%b idx=%0d re=%0d im=%0d sof=%b required valid=1 idx=%0d re=%0d im=%0d sof=%b",
                 i, out_valid, out_idx, $signed(out_re), $signed(out_im), out_sof, b, b + off, -(b + off), b == 0);
      end
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL run_end: out_valid=%b required 0 after %0d bins", out_valid, n);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++;
    if ({out_valid, out_re, out_im, out_idx, out_sof, ovf} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h required 0", {out_valid, out_re, out_im, out_idx, out_sof, ovf});
    end
    rst = 0;
  endtask

  task automatic test_order;
    int f;
    fork
      begin
        drive_frame(0, 0);
        @(negedge clk);
        in_valid = 0;
      end
      collect(32, 0, 0, f);
    join
  endtask

  task automatic test_latency;
    int f;
    fork
      begin
        drive_frame(3, 0);
        @(negedge clk);
        in_valid = 0;
      end
      collect(32, 3, 3, f);
    join
    total++;
    if (f !== t_last + 2) begin
      bad++;
      $display("FAIL latency: first valid cycle=%0d required %0d", f, t_last + 2);
    end
  endtask

  task automatic test_gaps;
    int f;
    fork
      begin
        drive_frame(0, 1);
        @(negedge clk);
        in_valid = 0;
      end
      collect(32, 0, 0, f);
    join
  endtask

  task automatic test_back_to_back;
    int f;
    fork
      begin
        drive_frame(0, 0);
        drive_frame(100, 0);
        @(negedge clk);
        in_valid = 0;
      end
      collect(64, 0, 100, f);
    join
    total++;
    if (ovf !== 1'b0) begin
      bad++;
      $display("FAIL b2b_ovf: ovf=%b required 0", ovf);
    end
  endtask

  task automatic test_overflow;
    int f;
    fork
      begin
        drive_frame(0, 0);
        drive_frame(100, 0);
        for (int p = 0; p < 16; p++) begin
          @(negedge clk);
          if (p < 2) begin
            total++;
            if (ovf !== (p == 1)) begin
              bad++;
              $display("FAIL ovf_edge%0d: ovf=%b required %b", p, ovf, p == 1);
            end
          end
          set_pair(p, 200);
        end
        @(negedge clk);
        in_valid = 0;
      end
      collect(64, 0, 100, f);
    join
    repeat (20) @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_tail: out_valid=%b ovf=%b required 0 and 1", out_valid, ovf);
    end
  endtask

  task automatic test_reset_midrun;
    int f, w;
    w = 0;
    fork
      begin
        drive_frame(7, 0);
        @(negedge clk);
        in_valid = 0;
      end
    join
    while (!out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    repeat (5) @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || ovf !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset: out_valid=%b ovf=%b required 1 and 1", out_valid, ovf);
    end
    #2 rst = 1;
    #1;
    total++;
    if ({out_valid, out_re, out_im, out_idx, out_sof, ovf} !== '0) begin
      bad++;
      $display("FAIL midrun_reset: got %h required 0", {out_valid, out_re, out_im, out_idx, out_sof, ovf});
    end
    @(negedge clk);
    rst = 0;
    fork
      begin
        drive_frame(50, 0);
        @(negedge clk);
        in_valid = 0;
      end
      collect(32, 50, 50, f);
    join
  endtask

  initial begin
    test_reset;
    test_order;
    test_latency;
    test_gaps;
    test_back_to_back;
    test_overflow;
    test_reset_midrun;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
